// File: rtl/safe_controller.sv
// Combination safe: encoder digit entry, lock state machine and an
// HD44780 status line refreshed continuously over an 8-bit bus.
module safe_controller #(
    parameter int unsigned div  = 2500,
    parameter logic [15:0] CODE = 16'h1234
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a,
    input  logic       b,
    input  logic       lock,
    input  logic       open,
    input  logic       doorCls,
    output logic       actuateLock,
    output logic       openCls,
    output logic       E,
    output logic       RW,
    output logic       RS,
    output logic [7:0] DB
);

    localparam logic [31:0] DIV_LAST    = 32'(div - 1);
    localparam logic [8:0]  POWER_LAST  = 9'd319;
    localparam logic [8:0]  CLEAR_LAST  = 9'd39;
    localparam logic [4:0]  SEQ_CLEAR   = 5'd3;
    localparam logic [4:0]  SEQ_HOME    = 5'd4;
    localparam logic [4:0]  SEQ_CHAR0   = 5'd5;
    localparam logic [4:0]  SEQ_LAST    = 5'd20;

    localparam logic [127:0] TXT_LOCKED = "LOCKED          ";
    localparam logic [127:0] TXT_WRONG  = "WRONG CODE      ";
    localparam logic [127:0] TXT_OPEN   = "OPEN            ";
    localparam logic [127:0] TXT_CODE   = "CODE:           ";

    typedef enum logic [1:0] {
        LOCKED,
        ENTRY,
        UNLOCKED
    } safe_state_t;

    typedef enum logic [2:0] {
        L_POWER,
        L_SETUP,
        L_PULSE,
        L_HOLD1,
        L_HOLD2,
        L_WAIT
    } lcd_state_t;

    // ---------------- input synchronisers and edge detect ----------------
    logic [4:0] sync1, sync2;       // {a, b, lock, open, doorCls}
    logic [2:0] prev;               // {a, lock, open}
    logic       a_rise, lock_rise, open_rise;
    logic       b_sync, door_sync;

    assign b_sync    = sync2[3];
    assign door_sync = sync2[0];

    // Edge pulses are registered so a pin change reaches the state register three clocks later.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1     <= '0;
            sync2     <= '0;
            prev      <= '0;
            a_rise    <= 1'b0;
            lock_rise <= 1'b0;
            open_rise <= 1'b0;
        end else begin
            sync1     <= {a, b, lock, open, doorCls};
            sync2     <= sync1;
            prev      <= {sync2[4], sync2[2], sync2[1]};
            a_rise    <= sync2[4] & ~prev[2];
            lock_rise <= sync2[2] & ~prev[1];
            open_rise <= sync2[1] & ~prev[0];
        end
    end

    // ---------------- lock state machine ----------------
    safe_state_t state, state_next;
    logic [3:0]  dial, dial_next;
    logic [1:0]  idx, idx_next;
    logic        err, err_next;
    logic        commit;
    logic [3:0]  digits [4];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOCKED;
            dial  <= '0;
            idx   <= '0;
            err   <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) digits[i] <= '0;
        end else begin
            state <= state_next;
            dial  <= dial_next;
            idx   <= idx_next;
            err   <= err_next;
            if (commit) digits[idx] <= dial;
        end
    end

    always_comb begin
        state_next = state;
        dial_next  = dial;
        idx_next   = idx;
        err_next   = err;
        commit     = 1'b0;
        case (state)
            LOCKED: begin
                if (open_rise) begin
                    state_next = ENTRY;
                    dial_next  = '0;
                    idx_next   = '0;
                    err_next   = 1'b0;
                end
            end
            ENTRY: begin
                if (lock_rise) begin
                    state_next = LOCKED;
                end else if (open_rise) begin
                    commit    = 1'b1;
                    dial_next = '0;
                    idx_next  = idx + 2'd1;
                    // The fourth digit is still in dial when the comparison is made.
                    if (idx == 2'd3) begin
                        if ({digits[0], digits[1], digits[2], dial} == CODE) begin
                            state_next = UNLOCKED;
                        end else begin
                            state_next = LOCKED;
                            err_next   = 1'b1;
                        end
                    end
                end else if (a_rise) begin
                    if (b_sync) dial_next = (dial == 4'd0) ? 4'd9 : dial - 4'd1;
                    else        dial_next = (dial == 4'd9) ? 4'd0 : dial + 4'd1;
                end
            end
            UNLOCKED: begin
                if (lock_rise && door_sync) state_next = LOCKED;
            end
            default: state_next = LOCKED;
        endcase
    end

    assign actuateLock = (state != UNLOCKED);
    assign openCls     = (state == UNLOCKED) & door_sync;

    // ---------------- LCD tick generator ----------------
    logic [31:0] tick_cnt;
    logic        tick;

    assign tick = (tick_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (reset) tick_cnt <= '0;
        else       tick_cnt <= tick ? '0 : tick_cnt + 32'd1;
    end

    // ---------------- LCD sequencer ----------------
    lcd_state_t lcd_state, lcd_next;
    logic [4:0] seq, seq_next;
    logic [8:0] wcnt;
    logic       load;
    logic       byte_rs;
    logic [7:0] byte_db;
    logic [7:0] ch;
    logic [3:0] pos;
    logic [4:0] star_end;

    function automatic logic [7:0] text_byte(input logic [127:0] s, input logic [3:0] p);
        return s[{4'(4'd15 - p), 3'b000} +: 8];
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            lcd_state <= L_POWER;
            seq       <= '0;
            wcnt      <= '0;
            RS        <= 1'b0;
            DB        <= '0;
        end else begin
            lcd_state <= lcd_next;
            seq       <= seq_next;
            if (tick && (lcd_state == L_POWER || lcd_state == L_WAIT))
                wcnt <= (lcd_next == L_SETUP) ? '0 : wcnt + 9'd1;
            if (load) begin
                RS <= byte_rs;
                DB <= byte_db;
            end
        end
    end

    always_comb begin
        lcd_next = lcd_state;
        seq_next = seq;
        load     = 1'b0;
        if (tick) begin
            case (lcd_state)
                L_POWER: begin
                    if (wcnt == POWER_LAST) begin
                        lcd_next = L_SETUP;
                        seq_next = '0;
                        load     = 1'b1;
                    end
                end
                L_SETUP: lcd_next = L_PULSE;
                L_PULSE: lcd_next = L_HOLD1;
                L_HOLD1: lcd_next = L_HOLD2;
                L_HOLD2: begin
                    if (seq == SEQ_CLEAR) begin
                        lcd_next = L_WAIT;
                    end else begin
                        lcd_next = L_SETUP;
                        load     = 1'b1;
                        seq_next = (seq == SEQ_LAST) ? SEQ_HOME : seq + 5'd1;
                    end
                end
                L_WAIT: begin
                    if (wcnt == CLEAR_LAST) begin
                        lcd_next = L_SETUP;
                        seq_next = SEQ_HOME;
                        load     = 1'b1;
                    end
                end
                default: lcd_next = L_POWER;
            endcase
        end
    end

    // Character for the byte about to be latched, taken from the live lock state.
    assign pos      = 4'(seq_next - SEQ_CHAR0);
    assign star_end = 5'd5 + {3'b000, idx};

    always_comb begin
        ch = " ";
        case (state)
            LOCKED:   ch = err ? text_byte(TXT_WRONG, pos) : text_byte(TXT_LOCKED, pos);
            UNLOCKED: ch = text_byte(TXT_OPEN, pos);
            ENTRY: begin
                if (pos < 4'd5)                   ch = text_byte(TXT_CODE, pos);
                else if ({1'b0, pos} < star_end)  ch = "*";
                else if ({1'b0, pos} == star_end) ch = 8'h30 + {4'h0, dial};
                else                              ch = " ";
            end
            default: ch = " ";
        endcase
    end

    always_comb begin
        byte_rs = 1'b0;
        byte_db = 8'h00;
        case (seq_next)
            5'd0:    byte_db = 8'h38;
            5'd1:    byte_db = 8'h0C;
            5'd2:    byte_db = 8'h06;
            5'd3:    byte_db = 8'h01;
            5'd4:    byte_db = 8'h80;
            default: begin
                byte_rs = 1'b1;
                byte_db = ch;
            end
        endcase
    end

    assign E  = (lcd_state == L_PULSE);
    assign RW = 1'b0;

endmodule

// File: tb/tb_safe_controller.sv
// Randomized bench for safe_controller: a behavioural model predicts lock
// outputs and status text; a monitor checks every LCD byte as it is strobed.
module tb_safe_controller;

    localparam logic [15:0] CODE_T = 16'h1234;
    localparam int POWER_WAIT = 320;
    localparam int BYTE_TICKS = 4;
    localparam int CLEAR_WAIT = 40;
    localparam int M_LOCKED = 0, M_ENTRY = 1, M_UNLOCKED = 2;

    logic clk = 0, reset = 1, a = 0, b = 0, lock = 0, open = 0, doorCls = 0;
    logic actuateLock, openCls, E, RW, RS;
    logic [7:0] DB;

    safe_controller #(.div(1), .CODE(CODE_T)) dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .lock(lock), .open(open),
        .doorCls(doorCls), .actuateLock(actuateLock), .openCls(openCls),
        .E(E), .RW(RW), .RS(RS), .DB(DB)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [8:0] rsdb;
        int         gap;
    } lcd_byte_t;

    lcd_byte_t init_q[$];
    string     frame_q[$];
    bit        armed = 0;
    int        last_e = 0;

    // behavioural model
    int  m_state = M_LOCKED;
    int  m_dial = 0;
    bit  m_err = 0;
    bit  m_door = 0;
    int  m_digs[$];

    function automatic void note(bit ok, string name, string got, string want);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got '%s' expected '%s'", name, got, want);
        end
    endfunction

    function automatic string model_text();
        string s;
        case (m_state)
            M_LOCKED: s = m_err ? "WRONG CODE" : "LOCKED";
            M_ENTRY: begin
                s = "CODE:";
                for (int i = 0; i < m_digs.size(); i++) s = {s, "*"};
                s = $sformatf("%s%0d", s, m_dial);
            end
            default: s = "OPEN";
        endcase
        while (s.len() < 16) s = {s, " "};
        return s;
    endfunction

    function automatic bit code_matches();
        for (int i = 0; i < 4; i++)
            if (m_digs[i] != int'((CODE_T >> (12 - 4 * i)) & 16'hF)) return 0;
        return 1;
    endfunction

    function automatic void model_open();
        if (m_state == M_LOCKED) begin
            m_state = M_ENTRY; m_dial = 0; m_err = 0; m_digs.delete();
        end else if (m_state == M_ENTRY) begin
            m_digs.push_back(m_dial);
            m_dial = 0;
            if (m_digs.size() == 4) begin
                if (code_matches()) m_state = M_UNLOCKED;
                else begin m_state = M_LOCKED; m_err = 1; end
                m_digs.delete();
            end
        end
    endfunction

    function automatic void model_lock();
        if (m_state == M_ENTRY) begin
            m_state = M_LOCKED; m_err = 0;
        end else if (m_state == M_UNLOCKED && m_door) begin
            m_state = M_LOCKED;
        end
    endfunction

    // monitor: one entry per E strobe
    initial begin
        string     fgot, fexp;
        int        fpos;
        logic      e_prev;
        lcd_byte_t ent;
        fpos = 16;
        e_prev = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                e_prev = 0; armed = 0; fpos = 16;
            end else begin
                if (E) begin
                    note(!e_prev, "e_width", "E high two cycles", "single-cycle E");
                    note(RW == 1'b0, "rw", $sformatf("%b", RW), "0");
                    if (init_q.size() > 0) begin
                        ent = init_q.pop_front();
                        note({RS, DB} == ent.rsdb, "init_byte",
                             $sformatf("%h", {RS, DB}), $sformatf("%h", ent.rsdb));
                        note(cyc - last_e == ent.gap, "init_gap",
                             $sformatf("%0d", cyc - last_e), $sformatf("%0d", ent.gap));
                    end
                    last_e = cyc;
                    if (!RS) begin
                        if (DB == 8'h80) begin
                            fpos = 0; fgot = "";
                            if (frame_q.size() > 0) begin
                                fexp = frame_q.pop_front();
                                armed = 1;
                            end
                        end
                    end else if (fpos < 16) begin
                        fgot = $sformatf("%s%c", fgot, DB);
                        fpos++;
                        if (fpos == 16 && armed) begin
                            note(fgot == fexp, "frame", fgot, fexp);
                            armed = 0;
                        end
                    end
                end
                e_prev = E;
            end
        end
    end

    task automatic tick_n(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_init();
        lcd_byte_t e;
        logic [7:0] cmds [5];
        string t;
        cmds = '{8'h38, 8'h0C, 8'h06, 8'h01, 8'h80};
        t = "LOCKED          ";
        for (int i = 0; i < 5; i++) begin
            e.rsdb = {1'b0, cmds[i]};
            e.gap  = (i == 0) ? POWER_WAIT + 1 : (i == 4) ? BYTE_TICKS + CLEAR_WAIT : BYTE_TICKS;
            init_q.push_back(e);
        end
        for (int i = 0; i < 16; i++) begin
            e.rsdb = {1'b1, 8'(t[i])};
            e.gap  = BYTE_TICKS;
            init_q.push_back(e);
        end
    endtask

    task automatic do_reset(bit check_e);
        reset = 1; a = 0; b = 0; lock = 0; open = 0;
        tick_n(1);
        if (check_e) note(E == 1'b0, "e_after_reset", $sformatf("%b", E), "0");
        tick_n(2);
        last_e = cyc;
        frame_q.delete();
        init_q.delete();
        m_state = M_LOCKED; m_dial = 0; m_err = 0; m_digs.delete();
        note(actuateLock == 1'b1, "rst_actuateLock", $sformatf("%b", actuateLock), "1");
        note(openCls == 1'b0, "rst_openCls", $sformatf("%b", openCls), "0");
        note(E == 1'b0, "rst_E", $sformatf("%b", E), "0");
        note({RS, DB} == 9'h000, "rst_bus", $sformatf("%h", {RS, DB}), "000");
        push_init();
        reset = 0;
    endtask

    task automatic wait_init();
        for (int i = 0; i < 800 && init_q.size() > 0; i++) tick_n(1);
        if (init_q.size() > 0) begin
            note(0, "init_timeout", $sformatf("%0d bytes left", init_q.size()), "0 bytes left");
            init_q.delete();
        end
    endtask

    task automatic check_outputs();
        tick_n(2);
        note(actuateLock == (m_state != M_UNLOCKED), "actuateLock",
             $sformatf("%b", actuateLock), $sformatf("%b", m_state != M_UNLOCKED));
        note(openCls == (m_state == M_UNLOCKED && m_door), "openCls",
             $sformatf("%b", openCls), $sformatf("%b", m_state == M_UNLOCKED && m_door));
    endtask

    task automatic expect_frame();
        frame_q.push_back(model_text());
        for (int i = 0; i < 400 && (frame_q.size() > 0 || armed); i++) tick_n(1);
        if (frame_q.size() > 0 || armed) begin
            note(0, "frame_timeout", "no frame", "frame");
            frame_q.delete();
            armed = 0;
        end
    endtask

    task automatic pulse_a(bit dir);
        b = dir; tick_n(1);
        a = 1; tick_n(3);
        a = 0; tick_n(3);
        if (m_state == M_ENTRY) m_dial = dir ? (m_dial + 9) % 10 : (m_dial + 1) % 10;
    endtask

    task automatic press_open();
        open = 1; tick_n(3); open = 0; tick_n(3);
        model_open();
    endtask

    task automatic press_lock();
        lock = 1; tick_n(3); lock = 0; tick_n(3);
        model_lock();
    endtask

    task automatic press_both();
        open = 1; lock = 1; tick_n(3); open = 0; lock = 0; tick_n(3);
        if (m_state == M_LOCKED) model_open();
        else model_lock();
    endtask

    task automatic set_door(bit v);
        doorCls = v; tick_n(3);
        m_door = v;
    endtask

    task automatic dial_commit(int d);
        repeat (d) pulse_a(0);
        press_open();
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset(0);
        wait_init();

        // correct code 1234 with door open
        set_door(0);
        press_open(); check_outputs(); expect_frame();
        for (int d = 1; d <= 4; d++) begin
            repeat (d) pulse_a(0);
            if (d == 3) expect_frame();
            press_open();
        end
        check_outputs(); expect_frame();

        // relock refused while door open, then honoured with exact latency
        press_lock(); check_outputs();
        set_door(1); check_outputs();
        lock = 1;
        tick_n(3);
        note(actuateLock == 1'b0, "lock_early", $sformatf("%b", actuateLock), "0");
        tick_n(1);
        note(actuateLock == 1'b1, "lock_latency", $sformatf("%b", actuateLock), "1");
        note(openCls == 1'b0, "cls_latency", $sformatf("%b", openCls), "0");
        lock = 0; tick_n(3);
        model_lock();
        check_outputs(); expect_frame();

        // wrong code, then re-entry
        press_open();
        repeat (4) press_open();
        check_outputs(); expect_frame();
        press_open(); expect_frame();

        // dial wrap in both directions
        pulse_a(1); expect_frame();
        pulse_a(0);
        repeat (10) pulse_a(0);
        expect_frame();

        // abort after two commits
        dial_commit(7); dial_commit(2); expect_frame();
        press_lock(); check_outputs(); expect_frame();

        // randomized operations
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 7))
                0, 1: repeat ($urandom_range(1, 3)) pulse_a(1'($urandom_range(0, 1)));
                2: press_open();
                3: press_lock();
                4: set_door(!m_door);
                5: press_both();
                6: begin
                    if (m_state == M_LOCKED) begin
                        press_open();
                        for (int i = 0; i < 4; i++)
                            dial_commit(int'((CODE_T >> (12 - 4 * i)) & 16'hF));
                    end else begin
                        pulse_a(0);
                    end
                end
                default: dial_commit($urandom_range(0, 9));
            endcase
            check_outputs();
            expect_frame();
        end

        // reset in the middle of a data byte
        for (int i = 0; i < 300 && !(E && RS); i++) tick_n(1);
        note(E && RS, "find_data_strobe", $sformatf("%b", E && RS), "1");
        do_reset(1);
        wait_init();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
